// File: rtl/scipio_pkg.sv
// Shared types and constants for the register status file.
// Tag all-ones means "no producer".
package scipio_pkg;

    localparam int XLEN      = 32;
    localparam int REG_NUM   = 32;
    localparam int REG_NUM_W = 5;
    localparam int TAG_W     = 5;
    localparam int CNT_W     = 6;

    localparam logic [TAG_W-1:0] TAG_INVALID = '1;

    typedef struct packed {
        logic             busy;
        logic [TAG_W-1:0] tag;
    } reg_status_t;

    localparam reg_status_t STATUS_IDLE = '{busy: 1'b0, tag: TAG_INVALID};

    // Population count of the busy vector.
    function automatic logic [CNT_W-1:0] busy_pop(input logic [REG_NUM-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/reg_read_port.sv
// One registered operand read port: x0 forcing and optional commit bypass.
// Build option: define REG_STATUS_BYPASS_EN to forward a same-cycle commit.
module reg_read_port
    import scipio_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en_i,
    input  logic [REG_NUM_W-1:0] addr_i,
    input  logic [XLEN-1:0]      raw_val_i,
    input  reg_status_t          raw_stat_i,
    input  logic [TAG_W-1:0]     cm_tag_i,
    input  logic [REG_NUM_W-1:0] cm_rd_i,
    input  logic [XLEN-1:0]      cm_data_i,
    output logic [XLEN-1:0]      val_o,
    output logic                 busy_o,
    output logic [TAG_W-1:0]     tag_o
);

    logic [XLEN-1:0] val_d, val_q;
    reg_status_t     stat_d, stat_q;

    // Select what the sampled address should return.
    always_comb begin
        val_d  = raw_val_i;
        stat_d = raw_stat_i;
        if (addr_i == '0) begin
            val_d  = '0;
            stat_d = STATUS_IDLE;
        end
`ifdef REG_STATUS_BYPASS_EN
        else if (cm_tag_i != TAG_INVALID && cm_rd_i == addr_i) begin
            val_d = cm_data_i;
            if (raw_stat_i.busy && raw_stat_i.tag == cm_tag_i) begin
                stat_d = STATUS_IDLE;
            end
        end
`endif
    end

`ifndef REG_STATUS_BYPASS_EN
    logic unused_cm;
    assign unused_cm = ^{cm_tag_i, cm_rd_i, cm_data_i};
`endif

    // Capture the lookup when enabled; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q  <= '0;
            stat_q <= STATUS_IDLE;
        end else if (rd_en_i) begin
            val_q  <= val_d;
            stat_q <= stat_d;
        end
    end

    assign val_o  = val_q;
    assign busy_o = stat_q.busy;
    assign tag_o  = stat_q.tag;

endmodule

// File: rtl/reg_status_file.sv
// Architectural registers plus rename status, fed by ROB commits.
// Build option: REG_STATUS_BYPASS_EN (see reg_read_port).
module reg_status_file
    import scipio_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic [REG_NUM_W-1:0] rs1_addr,
    input  logic [REG_NUM_W-1:0] rs2_addr,
    output logic [XLEN-1:0]      rs1_val,
    output logic                 rs1_busy,
    output logic [TAG_W-1:0]     rs1_tag,
    output logic [XLEN-1:0]      rs2_val,
    output logic                 rs2_busy,
    output logic [TAG_W-1:0]     rs2_tag,
    input  logic                 disp_en,
    input  logic [REG_NUM_W-1:0] disp_rd,
    input  logic [TAG_W-1:0]     disp_tag,
    input  logic [TAG_W-1:0]     cm_tag,
    input  logic [REG_NUM_W-1:0] cm_rd,
    input  logic [XLEN-1:0]      cm_data,
    input  logic                 flush,
    output logic [CNT_W-1:0]     busy_cnt,
    output logic [31:0]          retire_cnt
);

    logic [XLEN-1:0]    regs_q [REG_NUM];
    logic [XLEN-1:0]    regs_d [REG_NUM];
    reg_status_t        stat_q [REG_NUM];
    reg_status_t        stat_d [REG_NUM];
    logic [REG_NUM-1:0] busy_vec;
    logic [CNT_W-1:0]   busy_cnt_q;
    logic [31:0]        retire_cnt_q;
    logic               cm_v;

    assign cm_v = (cm_tag != TAG_INVALID);

    // Next state: commit, then flush or dispatch on top.
    always_comb begin
        regs_d   = regs_q;
        stat_d   = stat_q;
        busy_vec = '0;
        if (cm_v) begin
            if (cm_rd != '0) begin
                regs_d[cm_rd] = cm_data;
            end
            if (stat_q[cm_rd].busy && stat_q[cm_rd].tag == cm_tag) begin
                stat_d[cm_rd] = STATUS_IDLE;
            end
        end
        if (flush) begin
            for (int i = 0; i < REG_NUM; i++) begin
                stat_d[i] = STATUS_IDLE;
            end
        end else if (disp_en && disp_rd != '0) begin
            stat_d[disp_rd] = '{busy: 1'b1, tag: disp_tag};
        end
        for (int i = 0; i < REG_NUM; i++) begin
            busy_vec[i] = stat_d[i].busy;
        end
    end

    // Register file, status table and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
                stat_q[i] <= STATUS_IDLE;
            end
            busy_cnt_q   <= '0;
            retire_cnt_q <= '0;
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= regs_d[i];
                stat_q[i] <= stat_d[i];
            end
            busy_cnt_q <= busy_pop(busy_vec);
            if (cm_v) begin
                retire_cnt_q <= retire_cnt_q + 32'd1;
            end
        end
    end

    assign busy_cnt   = busy_cnt_q;
    assign retire_cnt = retire_cnt_q;

    reg_read_port u_rs1 (
        .clk        (clk),
        .rst        (rst),
        .rd_en_i    (rd_en),
        .addr_i     (rs1_addr),
        .raw_val_i  (regs_q[rs1_addr]),
        .raw_stat_i (stat_q[rs1_addr]),
        .cm_tag_i   (cm_tag),
        .cm_rd_i    (cm_rd),
        .cm_data_i  (cm_data),
        .val_o      (rs1_val),
        .busy_o     (rs1_busy),
        .tag_o      (rs1_tag)
    );

    reg_read_port u_rs2 (
        .clk        (clk),
        .rst        (rst),
        .rd_en_i    (rd_en),
        .addr_i     (rs2_addr),
        .raw_val_i  (regs_q[rs2_addr]),
        .raw_stat_i (stat_q[rs2_addr]),
        .cm_tag_i   (cm_tag),
        .cm_rd_i    (cm_rd),
        .cm_data_i  (cm_data),
        .val_o      (rs2_val),
        .busy_o     (rs2_busy),
        .tag_o      (rs2_tag)
    );

endmodule
